// File: rtl/dm_pkg.sv
// Shared types and widths for the data-memory access stage.
package dm_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic [DATA_W-1:0] data;
    } wb_t;

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/acknowledge data-memory port between the access unit and memory.
interface dm_access_unit_if;
    import dm_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/dm_timeout_ctr.sv
// Counts WAIT cycles of an outstanding access; expire flags the last allowed cycle.
module dm_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear has priority so a fresh access always starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory stage controller: issues loads/stores on the memory port, stalls
// upstream while busy, and registers the writeback bundle for the DM/WB stage.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    output logic              stall,
    dm_access_unit_if.master  mem,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic              align_err,
    output logic              bus_err
);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    wb_t               wb_q, wb_d;
    logic              align_q, align_d;
    logic              bus_q, bus_d;
    logic [REG_W-1:0]  lat_rd_q, lat_rd_d;
    logic              lat_rw_q, lat_rw_d;
    logic              lat_m2r_q, lat_m2r_d;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_expire;

    logic access;
    logic illegal;

    assign access  = valid_in & (mem_read_in | mem_write_in);
    assign illegal = access & ((addr_in[1:0] != 2'b00) | (mem_read_in & mem_write_in));

    dm_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .expire(ctr_expire)
    );

    // Next-state, memory request and writeback bundle; pulses default low each edge.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wb_d         = wb_q;
        wb_d.valid   = 1'b0;
        align_d      = 1'b0;
        bus_d        = 1'b0;
        lat_rd_d     = lat_rd_q;
        lat_rw_d     = lat_rw_q;
        lat_m2r_d    = lat_m2r_q;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!access) begin
                    if (valid_in) begin
                        wb_d.valid     = 1'b1;
                        wb_d.rd        = rd_in;
                        wb_d.reg_write = reg_write_in;
                        wb_d.data      = addr_in;
                    end
                end else if (illegal) begin
                    // Illegal accesses retire immediately with no register write.
                    align_d        = 1'b1;
                    wb_d.valid     = 1'b1;
                    wb_d.rd        = rd_in;
                    wb_d.reg_write = 1'b0;
                    wb_d.data      = addr_in;
                end else begin
                    stall     = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_write_in;
                    addr_d    = {addr_in[ADDR_W-1:2], 2'b00};
                    wdata_d   = wdata_in;
                    lat_rd_d  = rd_in;
                    lat_rw_d  = reg_write_in;
                    lat_m2r_d = mem_to_reg_in;
                    ctr_clr   = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // Ack is checked first so it wins over a coincident timeout.
                if (mem.mem_ack) begin
                    req_d          = 1'b0;
                    wb_d.valid     = 1'b1;
                    wb_d.rd        = lat_rd_q;
                    wb_d.reg_write = lat_rw_q;
                    wb_d.data      = lat_m2r_q ? mem.mem_rdata : addr_q;
                    state_d        = DONE;
                end else if (ctr_expire) begin
                    req_d          = 1'b0;
                    bus_d          = 1'b1;
                    wb_d.valid     = 1'b1;
                    wb_d.rd        = lat_rd_q;
                    wb_d.reg_write = 1'b0;
                    state_d        = DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                // Upstream advances past the finished instruction on this edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No pipeline advance is meaningful while reset is held.
        if (reset) begin
            stall = 1'b0;
        end
    end

    // State, request and writeback registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= '0;
            align_q   <= 1'b0;
            bus_q     <= 1'b0;
            lat_rd_q  <= '0;
            lat_rw_q  <= 1'b0;
            lat_m2r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            align_q   <= align_d;
            bus_q     <= bus_d;
            lat_rd_q  <= lat_rd_d;
            lat_rw_q  <= lat_rw_d;
            lat_m2r_q <= lat_m2r_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign wb_valid     = wb_q.valid;
    assign wb_rd        = wb_q.rd;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_data      = wb_q.data;
    assign align_err    = align_q;
    assign bus_err      = bus_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: single-cycle vector table plus memory sequences.
module tb_dm_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [31:0] addr_in, wdata_in;
    logic [4:0]  rd_in;
    logic        mem_to_reg_in, reg_write_in;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        align_err, bus_err;

    int total = 0;
    int bad   = 0;

    dm_access_unit_if mif ();

    dm_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .rd_in        (rd_in),
        .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in (reg_write_in),
        .stall        (stall),
        .mem          (mif),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .align_err    (align_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rd, wr, m2r, rw;
        logic [31:0] addr;
        logic [4:0]  rdi;
        logic        full;
        logic        e_wbv, e_rw, e_align;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_seq(input string nm, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] r, input logic m2r,
                           input int k, input logic [31:0] rdat, input logic exp_bus,
                           input logic exp_rw, input logic chk_data, input logic [31:0] exp_data);
        int st;
        int cyc;
        int exp_cyc;
        logic req_dropped;
        valid_in      = 1'b1;
        mem_read_in   = ~we;
        mem_write_in  = we;
        addr_in       = a;
        wdata_in      = wd;
        rd_in         = r;
        mem_to_reg_in = m2r;
        reg_write_in  = 1'b1;
        #1;
        st = stall ? 1 : 0;
        tick();
        chk({nm, " req"}, {31'd0, mif.mem_req}, 32'd1);
        chk({nm, " we"}, {31'd0, mif.mem_we}, {31'd0, we});
        chk({nm, " addr"}, mif.mem_addr, a);
        if (we) chk({nm, " wdata"}, mif.mem_wdata, wd);
        cyc = 0;
        req_dropped = 1'b0;
        while (!wb_valid && cyc < 40) begin
            if (stall) st++;
            if (!mif.mem_req) req_dropped = 1'b1;
            cyc++;
            if (cyc == k) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdat;
            end
            tick();
            mif.mem_ack = 1'b0;
        end
        exp_cyc = (k > 0) ? k : TO;
        chk({nm, " wait cycles"}, cyc, exp_cyc);
        chk({nm, " req held"}, {31'd0, req_dropped}, 32'd0);
        chk({nm, " stall cycles"}, st, exp_cyc + 1);
        chk({nm, " done wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({nm, " done req"}, {31'd0, mif.mem_req}, 32'd0);
        chk({nm, " done stall"}, {31'd0, stall}, 32'd0);
        chk({nm, " bus_err"}, {31'd0, bus_err}, {31'd0, exp_bus});
        chk({nm, " wb_rw"}, {31'd0, wb_reg_write}, {31'd0, exp_rw});
        chk({nm, " wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
        if (chk_data) chk({nm, " wb_data"}, wb_data, exp_data);
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        tick();
        chk({nm, " after wbv"}, {31'd0, wb_valid}, 32'd0);
        chk({nm, " after bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        valid_in      = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        addr_in       = '0;
        wdata_in      = '0;
        rd_in         = '0;
        mem_to_reg_in = 1'b0;
        reg_write_in  = 1'b0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        //          v  rd wr m2r rw addr          rdi full wbv rw al  e_rd  e_data
        vecs[0] = '{1, 0, 0, 0, 1, 32'h0000_1234, 5,  1,  1,  1, 0,  5,  32'h0000_1234};
        vecs[1] = '{0, 0, 0, 0, 1, 32'h0000_5555, 9,  0,  0,  0, 0,  0,  32'h0};
        vecs[2] = '{1, 1, 0, 1, 1, 32'h0000_0042, 3,  0,  1,  0, 1,  0,  32'h0};
        vecs[3] = '{1, 0, 0, 0, 0, 32'hFFFF_FFFF, 31, 1,  1,  0, 0,  31, 32'hFFFF_FFFF};
        vecs[4] = '{1, 1, 1, 1, 1, 32'h0000_0040, 4,  0,  1,  0, 1,  0,  32'h0};
        vecs[5] = '{1, 0, 1, 0, 1, 32'h0000_0083, 6,  0,  1,  0, 1,  0,  32'h0};
        vecs[6] = '{0, 1, 0, 1, 1, 32'h0000_0042, 7,  0,  0,  0, 0,  0,  32'h0};
        vecs[7] = '{1, 0, 0, 0, 1, 32'h0000_0003, 12, 1,  1,  1, 0,  12, 32'h0000_0003};

        #3;
        chk("rst req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst addr", mif.mem_addr, 32'd0);
        chk("rst wdata", mif.mem_wdata, 32'd0);
        chk("rst wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst align", {31'd0, align_err}, 32'd0);
        chk("rst bus", {31'd0, bus_err}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            valid_in      = vecs[i].v;
            mem_read_in   = vecs[i].rd;
            mem_write_in  = vecs[i].wr;
            mem_to_reg_in = vecs[i].m2r;
            reg_write_in  = vecs[i].rw;
            addr_in       = vecs[i].addr;
            rd_in         = vecs[i].rdi;
            #1;
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, 32'd0);
            tick();
            chk($sformatf("vec%0d req", i), {31'd0, mif.mem_req}, 32'd0);
            chk($sformatf("vec%0d wbv", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_wbv});
            chk($sformatf("vec%0d align", i), {31'd0, align_err}, {31'd0, vecs[i].e_align});
            if (vecs[i].e_wbv)
                chk($sformatf("vec%0d wb_rw", i), {31'd0, wb_reg_write}, {31'd0, vecs[i].e_rw});
            if (vecs[i].full) begin
                chk($sformatf("vec%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].e_rd});
                chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
            end
        end

        // Load, ack after one cycle.
        mem_seq("load1", 1'b0, 32'h40, 32'h0, 5'd7, 1'b1, 1, 32'hDEAD_BEEF,
                1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        // Store, ack after three cycles; writeback value is the address.
        mem_seq("store3", 1'b1, 32'h80, 32'hA5A5_A5A5, 5'd9, 1'b0, 3, 32'h1111_1111,
                1'b0, 1'b1, 1'b1, 32'h80);
        // No ack: timeout after TO WAIT cycles.
        mem_seq("timeout", 1'b0, 32'h44, 32'h0, 5'd10, 1'b1, 0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0);
        // Ack on the timeout edge wins.
        mem_seq("ack_at_to", 1'b0, 32'h48, 32'h0, 5'd11, 1'b1, TO, 32'hCAFE_F00D,
                1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);

        // Reset during WAIT abandons the transaction.
        valid_in      = 1'b1;
        mem_read_in   = 1'b1;
        mem_write_in  = 1'b0;
        addr_in       = 32'h100;
        rd_in         = 5'd3;
        mem_to_reg_in = 1'b1;
        reg_write_in  = 1'b1;
        tick();
        chk("rstw req before", {31'd0, mif.mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw req", {31'd0, mif.mem_req}, 32'd0);
        chk("rstw stall", {31'd0, stall}, 32'd0);
        chk("rstw wbv", {31'd0, wb_valid}, 32'd0);
        tick();
        valid_in    = 1'b0;
        mem_read_in = 1'b0;
        reset       = 1'b0;
        tick();
        chk("rstw post wbv", {31'd0, wb_valid}, 32'd0);
        chk("rstw post bus", {31'd0, bus_err}, 32'd0);
        chk("rstw post align", {31'd0, align_err}, 32'd0);
        mem_seq("load_after_rst", 1'b0, 32'h44, 32'h0, 5'd12, 1'b1, 2, 32'h1234_5678,
                1'b0, 1'b1, 1'b1, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
